jtkcpu_stack_seq: RTL



---
 rtl/jtkcpu_stack_seq_if.sv | 33 +++
 rtl/jtkcpu_stack_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/jtkcpu_stack_seq_if.sv
// rtl/jtkcpu_stack_seq_if.sv - request/bus bundle between the CPU core and the stack sequencer
interface jtkcpu_stack_seq_if;
    logic       psh_req;
    logic       pul_req;
    logic       int_req;
    logic       firq_req;
    logic [7:0] postbyte;
    logic       ussel_in;
    logic       mem_wait;
    logic [7:0] psh_sel;
    logic       psh_hihalf;
    logic       psh_ussel;
    logic       psh_dec;
    logic       pul_en;
    logic       stack_busy;
    logic       mem_wr;
    logic       mem_rd;
    logic       busy;
    logic       done;
    logic [3:0] byte_cnt;

    modport master (
        output psh_req, pul_req, int_req, firq_req, postbyte, ussel_in, mem_wait,
        input  psh_sel, psh_hihalf, psh_ussel, psh_dec, pul_en, stack_busy,
        input  mem_wr, mem_rd, busy, done, byte_cnt
    );

    modport slave (
        input  psh_req, pul_req, int_req, firq_req, postbyte, ussel_in, mem_wait,
        output psh_sel, psh_hihalf, psh_ussel, psh_dec, pul_en, stack_busy,
        output mem_wr, mem_rd, busy, done, byte_cnt
    );
endinterface

// File: rtl/jtkcpu_stack_seq.sv
// rtl/jtkcpu_stack_seq.sv - PSH/PUL/interrupt stack byte sequencer; JTKCPU_STACK_CNT_EN adds a byte counter
module jtkcpu_stack_seq #(
    parameter logic [7:0] INT_MASK  = 8'hFF,
    parameter logic [7:0] FIRQ_MASK = 8'h81
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    jtkcpu_stack_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PSH_DEC = 3'd1,
        PSH_WR  = 3'd2,
        PUL_RD  = 3'd3,
        PUL_WB  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] mask, mask_nxt;
    logic       hihalf, hihalf_nxt;
    logic       ussel, ussel_nxt;
    logic       start_pul;
    logic       any_req;

    // Index of the highest set bit; pushes walk the mask from the top down.
    function automatic logic [2:0] hi_bit(input logic [7:0] m);
        hi_bit = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) hi_bit = 3'(i);
        end
    endfunction

    // The lowest set bit is a 16-bit register exactly when bits 3..0 are all clear.
    function automatic logic lo_wide(input logic [7:0] m);
        lo_wide = (m[3:0] == 4'd0) && (m[7:4] != 4'd0);
    endfunction

    assign any_req = bus.int_req | bus.firq_req | bus.psh_req | bus.pul_req;

    always_comb begin
        state_nxt  = state;
        mask_nxt   = mask;
        hihalf_nxt = hihalf;
        ussel_nxt  = ussel;
        start_pul  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (bus.int_req) begin
                        mask_nxt  = INT_MASK;
                        ussel_nxt = 1'b0;
                    end else if (bus.firq_req) begin
                        mask_nxt  = FIRQ_MASK;
                        ussel_nxt = 1'b0;
                    end else begin
                        mask_nxt  = bus.postbyte;
                        ussel_nxt = bus.ussel_in;
                        start_pul = ~bus.psh_req;
                    end
                    // A pull of a wide register starts on its high byte.
                    hihalf_nxt = start_pul & lo_wide(mask_nxt);
                    if (mask_nxt == 8'd0)
                        state_nxt = DONE;
                    else
                        state_nxt = start_pul ? PUL_RD : PSH_DEC;
                end
            end
            PSH_DEC: state_nxt = PSH_WR;
            PSH_WR: begin
                if (!bus.mem_wait) begin
                    if ((mask[7:4] != 4'd0) && !hihalf) begin
                        hihalf_nxt = 1'b1;
                        state_nxt  = PSH_DEC;
                    end else begin
                        mask_nxt   = mask & ~(8'd1 << hi_bit(mask));
                        hihalf_nxt = 1'b0;
                        state_nxt  = (mask_nxt == 8'd0) ? DONE : PSH_DEC;
                    end
                end
            end
            PUL_RD: begin
                if (!bus.mem_wait) state_nxt = PUL_WB;
            end
            PUL_WB: begin
                if (lo_wide(mask) && hihalf) begin
                    hihalf_nxt = 1'b0;
                    state_nxt  = PUL_RD;
                end else begin
                    mask_nxt   = mask & (mask - 8'd1);
                    hihalf_nxt = lo_wide(mask_nxt);
                    state_nxt  = (mask_nxt == 8'd0) ? DONE : PUL_RD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mask   <= 8'd0;
            hihalf <= 1'b0;
            ussel  <= 1'b0;
        end else if (cen) begin
            state  <= state_nxt;
            mask   <= mask_nxt;
            hihalf <= hihalf_nxt;
            ussel  <= ussel_nxt;
        end
    end

    assign bus.psh_sel    = mask;
    assign bus.psh_hihalf = hihalf;
    assign bus.psh_ussel  = ussel;
    assign bus.psh_dec    = (state == PSH_DEC);
    assign bus.mem_wr     = (state == PSH_WR);
    assign bus.pul_en     = (state == PUL_RD);
    assign bus.mem_rd     = (state == PUL_RD);
    // One pointer increment per pulled byte: only on the cen that completes the read.
    assign bus.stack_busy = cen & (state == PUL_RD) & ~bus.mem_wait;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);

`ifdef JTKCPU_STACK_CNT_EN
    logic [3:0] cnt;
    logic       cnt_clr;
    logic       cnt_inc;

    assign cnt_clr = (state == IDLE) & any_req;
    assign cnt_inc = ~bus.mem_wait & ((state == PSH_WR) | (state == PUL_RD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 4'd0;
        else if (cen) begin
            if (cnt_clr)
                cnt <= 4'd0;
            else if (cnt_inc)
                cnt <= cnt + 4'd1;
        end
    end

    assign bus.byte_cnt = cnt;
`else
    assign bus.byte_cnt = 4'd0;
`endif

endmodule
